// File: rtl/calculus_requant_stage_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : calculus_requant_stage_if
// Purpose  : Stream bundle for the requantization stage. It carries the
//            input beat (data, function code, per-beat format fields), the
//            output beat (data, saturation flag) and both handshakes.
//            The master drives the input beat and out_ready. The slave (the
//            stage) drives in_ready and the output beat.
// Revision : 1.0 - initial release
// ============================================================================
interface calculus_requant_stage_if #(
  parameter int BIT_WIDTH     = 32,
  parameter int FUNCTION_BITS = 4
);

  // Input side handshake and beat payload
  logic                     in_valid;
  logic                     in_ready;
  logic [BIT_WIDTH-1:0]     in_data;
  logic [FUNCTION_BITS-1:0] in_fn;
  logic [7:0]               src_integer_bits;
  logic [7:0]               dest_integer_bits;

  // Output side handshake and beat payload
  logic                     out_valid;
  logic                     out_ready;
  logic [BIT_WIDTH-1:0]     out_data;
  logic                     out_sat;

  // Producer of calculus results and consumer of requantized results
  modport master (
    output in_valid, in_data, in_fn, src_integer_bits, dest_integer_bits,
    output out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  // The requantization stage itself
  modport slave (
    input  in_valid, in_data, in_fn, src_integer_bits, dest_integer_bits,
    input  out_ready,
    output in_ready, out_valid, out_data, out_sat
  );

endinterface
`default_nettype wire

// File: rtl/calculus_requant_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : calculus_requant_stage
// Purpose  : Downstream stage of the SIMD calculus unit. Each result is
//            re-scaled from its source fixed-point format to the destination
//            fixed-point format by shifting, with saturation on left-shift
//            overflow. The stage is a 2-deep valid/ready pipeline, so
//            writeback backpressure never drops a beat. A sticky saturation
//            event counter is provided for status readout.
// Options  : CALC_REQUANT_ROUND_EN - when defined, right shifts round half
//            toward +inf instead of truncating. Latency and handshake do not
//            change.
// Revision : 1.0 - initial release
// ============================================================================
module calculus_requant_stage #(
  parameter int BIT_WIDTH     = 32,
  parameter int FUNCTION_BITS = 4,
  parameter int SAT_CNT_BITS  = 16
) (
  input  logic                    clk,
  input  logic                    reset,      // asynchronous, active low
  calculus_requant_stage_if.slave bus,
  input  logic                    clear_sat,
  output logic [SAT_CNT_BITS-1:0] sat_count
);

  // Signed shift width. It holds +/-(BIT_WIDTH-1) and also the clamped
  // integer-bit counts (up to BIT_WIDTH) as positive signed values.
  localparam int SW = $clog2(BIT_WIDTH) + 2;

  // Function code whose result is a pure integer (the sign function)
  localparam logic [FUNCTION_BITS-1:0] FN_SIGN = FUNCTION_BITS'(3);

  localparam logic [BIT_WIDTH-1:0] SAT_POS = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic [BIT_WIDTH-1:0] SAT_NEG = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  // Limit an integer-bit field to the legal range [1, BIT_WIDTH]
  function automatic logic [SW-1:0] clamp_ib(input logic [7:0] v);
    if (v == 8'd0) begin
      return SW'(1);
    end
    if (int'(v) > BIT_WIDTH) begin
      return SW'(BIT_WIDTH);
    end
    return SW'(v);
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                     s1_valid_q, s1_valid_d;
  logic [BIT_WIDTH-1:0]     s1_data_q,  s1_data_d;
  logic [FUNCTION_BITS-1:0] s1_fn_q,    s1_fn_d;
  logic [7:0]               s1_src_q,   s1_src_d;
  logic [7:0]               s1_dest_q,  s1_dest_d;

  logic                     out_valid_q, out_valid_d;
  logic [BIT_WIDTH-1:0]     out_data_q,  out_data_d;
  logic                     out_sat_q,   out_sat_d;

  logic [SAT_CNT_BITS-1:0]  sat_count_q, sat_count_d;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic s2_adv;
  logic in_ready;
  logic out_xfer;

  // Output register may load when it is empty or being drained this cycle
  assign s2_adv   = !out_valid_q || bus.out_ready;
  // Stage 1 may accept when empty or when its beat moves on this cycle
  assign in_ready = !s1_valid_q || s2_adv;
  assign out_xfer = out_valid_q && bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign sat_count     = sat_count_q;

  // --------------------------------------------------------------------------
  // Shift amount derived from the registered per-beat format fields
  // --------------------------------------------------------------------------
  logic        [SW-1:0] src_ib;
  logic        [SW-1:0] dest_ib;
  logic signed [SW-1:0] shift;
  logic        [SW-1:0] shift_mag;

  // Sign results carry no fraction, so their source format is all integer
  assign src_ib    = (s1_fn_q == FN_SIGN) ? SW'(BIT_WIDTH) : clamp_ib(s1_src_q);
  assign dest_ib   = clamp_ib(s1_dest_q);
  assign shift     = $signed(dest_ib) - $signed(src_ib);
  assign shift_mag = shift[SW-1] ? $unsigned(-shift) : $unsigned(shift);

  // --------------------------------------------------------------------------
  // Shift datapath
  // --------------------------------------------------------------------------
  logic signed [BIT_WIDTH-1:0] operand;
  logic signed [BIT_WIDTH-1:0] right_res;
  logic signed [BIT_WIDTH-1:0] left_res;
  logic signed [BIT_WIDTH-1:0] left_back;
  logic                        left_ovf;

  assign operand = $signed(s1_data_q);

  // A left shift overflowed exactly when shifting back does not restore the
  // operand, i.e. the top k+1 bits were not all copies of the sign bit.
  assign left_res  = operand <<< shift_mag;
  assign left_back = left_res >>> shift_mag;
  assign left_ovf  = (left_back != operand);

`ifdef CALC_REQUANT_ROUND_EN
  // Add half an output LSB before flooring. One extra bit of headroom keeps
  // the sum from wrapping, and the shifted result always fits again.
  logic signed [BIT_WIDTH:0] round_sum;
  assign round_sum = $signed({operand[BIT_WIDTH-1], operand})
                   + $signed((BIT_WIDTH+1)'(1) << (shift_mag - SW'(1)));
  assign right_res = BIT_WIDTH'(round_sum >>> shift_mag);
`else
  // Plain arithmetic shift floors toward -inf
  assign right_res = operand >>> shift_mag;
`endif

  logic [BIT_WIDTH-1:0] s2_data;
  logic                 s2_sat;

  // Select pass-through, right shift, left shift or saturated value
  always_comb begin
    s2_data = operand;
    s2_sat  = 1'b0;
    if (shift == '0) begin
      s2_data = operand;
    end else if (!shift[SW-1]) begin
      s2_data = right_res;
    end else if (left_ovf) begin
      s2_data = operand[BIT_WIDTH-1] ? SAT_NEG : SAT_POS;
      s2_sat  = 1'b1;
    end else begin
      s2_data = left_res;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------

  // Stage 1 captures the raw beat whenever it can accept
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_fn_d    = s1_fn_q;
    s1_src_d   = s1_src_q;
    s1_dest_d  = s1_dest_q;
    if (in_ready) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_data_d = bus.in_data;
        s1_fn_d   = bus.in_fn;
        s1_src_d  = bus.src_integer_bits;
        s1_dest_d = bus.dest_integer_bits;
      end
    end
  end

  // Output register loads the requantized beat; it holds while stalled
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = s2_data;
        out_sat_d  = s2_sat;
      end
    end
  end

  // Saturation counter: counts delivered saturated beats, sticks at max,
  // and a clear request overrides a coincident increment
  always_comb begin
    sat_count_d = sat_count_q;
    if (clear_sat) begin
      sat_count_d = '0;
    end else if (out_xfer && out_sat_q && (sat_count_q != '1)) begin
      sat_count_d = sat_count_q + SAT_CNT_BITS'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------

  // Stage 1 register; reset discards any in-flight beat
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_fn_q    <= '0;
      s1_src_q   <= '0;
      s1_dest_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_fn_q    <= s1_fn_d;
      s1_src_q   <= s1_src_d;
      s1_dest_q  <= s1_dest_d;
    end
  end

  // Output register and saturation counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      sat_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      sat_count_q <= sat_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_calculus_requant_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_calculus_requant_stage
// Purpose  : Self-checking bench for calculus_requant_stage. The stimulus
//            pushes expected beats into a scoreboard queue and a negedge
//            monitor pops and compares every delivered beat. It also tracks
//            the expected saturation count and output stability under stall.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calculus_requant_stage;

  localparam int BW = 32;
  localparam int FB = 4;
  localparam int CB = 16;

  logic          clk       = 1'b0;
  logic          reset     = 1'b0;
  logic          clear_sat = 1'b0;
  logic [CB-1:0] sat_count;

  calculus_requant_stage_if #(.BIT_WIDTH(BW), .FUNCTION_BITS(FB)) bus ();

  calculus_requant_stage #(
    .BIT_WIDTH     (BW),
    .FUNCTION_BITS (FB),
    .SAT_CNT_BITS  (CB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .clear_sat (clear_sat),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [BW:0] sb[$];          // {sat, data}
  int          exp_cnt = 0;
  logic        hold_v  = 1'b0;
  logic [BW:0] hold_val;
  logic [BW:0] mon_e;
  logic        mon_esat;
  bit          rand_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (plain integer arithmetic) ----------------
  function automatic int clampi(input logic [7:0] v);
    if (int'(v) < 1)  return 1;
    if (int'(v) > BW) return BW;
    return int'(v);
  endfunction

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic logic [BW:0] model(input logic [BW-1:0] data, input logic [FB-1:0] fn,
                                        input logic [7:0] src, input logic [7:0] dst);
    int     s, d;
    longint v, r, hi, lo;
    logic   sat;
    s   = (fn == 4'b0011) ? BW : clampi(src);
    d   = clampi(dst) - s;
    v   = longint'($signed(data));
    hi  = (64'sd1 <<< (BW - 1)) - 1;
    lo  = -(64'sd1 <<< (BW - 1));
    sat = 1'b0;
    if (d == 0) begin
      r = v;
    end else if (d > 0) begin
`ifdef CALC_REQUANT_ROUND_EN
      r = fdiv(v + (64'sd1 <<< (d - 1)), 64'sd1 <<< d);
`else
      r = fdiv(v, 64'sd1 <<< d);
`endif
    end else begin
      r = v * (64'sd1 <<< (-d));
      if (r > hi) begin r = hi; sat = 1'b1; end
      if (r < lo) begin r = lo; sat = 1'b1; end
    end
    return {sat, r[BW-1:0]};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (reset) begin
      chk("sat_count", 64'(sat_count), 64'(exp_cnt));
      if (hold_v) begin
        chk("hold_valid", 64'(bus.out_valid), 64'(1));
        chk("hold_data", 64'({bus.out_sat, bus.out_data}), 64'(hold_val));
      end
      hold_v   = bus.out_valid && !bus.out_ready;
      hold_val = {bus.out_sat, bus.out_data};
      mon_esat = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got 0x%0h with no beat outstanding", bus.out_data);
        end else begin
          mon_e    = sb.pop_front();
          mon_esat = mon_e[BW];
          chk("out_data", 64'(bus.out_data), 64'(mon_e[BW-1:0]));
          chk("out_sat", 64'(bus.out_sat), 64'(mon_e[BW]));
        end
      end
      if (clear_sat) exp_cnt = 0;
      else if (mon_esat && exp_cnt != (1 << CB) - 1) exp_cnt++;
    end else begin
      hold_v = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [BW-1:0] data, input logic [FB-1:0] fn,
                      input logic [7:0] src, input logic [7:0] dst,
                      input bit use_exp, input logic [BW:0] exp);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    bus.in_valid          = 1'b1;
    bus.in_data           = data;
    bus.in_fn             = fn;
    bus.src_integer_bits  = src;
    bus.dest_integer_bits = dst;
    while (!acc) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      if (acc) sb.push_back(use_exp ? exp : model(data, fn, src, dst));
      #1;
      n++;
      if (!acc && n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d beats still outstanding", sb.size());
    end
  endtask

  // Checks out_valid two edges after an acceptance that just completed
  task automatic latency_check(input string tag, input logic [BW-1:0] exp_data);
    @(negedge clk);
    chk({tag, "_valid_c1"}, 64'(bus.out_valid), 64'(0));
    @(negedge clk);
    chk({tag, "_valid_c2"}, 64'(bus.out_valid), 64'(1));
    chk({tag, "_data_c2"}, 64'(bus.out_data), 64'(exp_data));
    @(posedge clk);
    #1;
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    logic [BW-1:0] rd;
    logic [FB-1:0] rf;
    int            n;

    bus.in_valid          = 1'b0;
    bus.in_data           = '0;
    bus.in_fn             = '0;
    bus.src_integer_bits  = '0;
    bus.dest_integer_bits = '0;
    bus.out_ready         = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_out_sat", 64'(bus.out_sat), 64'(0));
    chk("rst_sat_count", 64'(sat_count), 64'(0));
    reset = 1'b1;

    // Pass-through with latency check
    send(32'h00012345, 4'h0, 8'd16, 8'd16, 1'b1, {1'b0, 32'h00012345});
    latency_check("pass", 32'h00012345);

    // Right shift, src=8 dest=16
`ifdef CALC_REQUANT_ROUND_EN
    send(32'h00001280, 4'h0, 8'd8, 8'd16, 1'b1, {1'b0, 32'h00000013});
    send(32'hFFFFFFFF, 4'h0, 8'd8, 8'd16, 1'b1, {1'b0, 32'h00000000});
`else
    send(32'h00001280, 4'h0, 8'd8, 8'd16, 1'b1, {1'b0, 32'h00000012});
    send(32'hFFFFFFFF, 4'h0, 8'd8, 8'd16, 1'b1, {1'b0, 32'hFFFFFFFF});
`endif
    // Left shift, src=16 dest=8
    send(32'h00800000, 4'h0, 8'd16, 8'd8, 1'b1, {1'b1, 32'h7FFFFFFF});
    send(32'hFF800000, 4'h0, 8'd16, 8'd8, 1'b1, {1'b0, 32'h80000000});
    drain();
    chk("sat_count_left", 64'(sat_count), 64'(1));

    // Sign path: source treated as pure integer
    send(32'hFFFFFFFF, 4'h3, 8'd8, 8'd16, 1'b1, {1'b0, 32'hFFFF0000});
    send(32'h00000001, 4'h3, 8'd8, 8'd1,  1'b1, {1'b1, 32'h7FFFFFFF});
    drain();
    chk("sat_count_sign", 64'(sat_count), 64'(2));

    // Backpressure: 4 back-to-back beats, out_ready low for 5 cycles
    bus.out_ready = 1'b0;
    fork
      begin
        send(32'h00800000, 4'h0, 8'd16, 8'd8,  1'b0, '0);
        send(32'h00001280, 4'h0, 8'd8,  8'd16, 1'b0, '0);
        send(32'h00012345, 4'h0, 8'd16, 8'd16, 1'b0, '0);
        send(32'hFF800000, 4'h0, 8'd16, 8'd8,  1'b0, '0);
      end
      begin
        repeat (2) @(posedge clk);
        #2;
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'(0));
        chk("bp_out_valid", 64'(bus.out_valid), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("bp_stream_valid", 64'(bus.out_valid), 64'(1));
        end
      end
    join
    drain();
    chk("sat_count_bp", 64'(sat_count), 64'(3));

    // clear_sat coincident with a saturating transfer
    bus.out_ready = 1'b0;
    send(32'h00800000, 4'h0, 8'd16, 8'd8, 1'b1, {1'b1, 32'h7FFFFFFF});
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("clr_out_valid", 64'(bus.out_valid), 64'(1));
    clear_sat     = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    clear_sat = 1'b0;
    chk("sat_clear_wins", 64'(sat_count), 64'(0));
    drain();

    // Reset mid-stream with 2 beats in flight
    send(32'h00800000, 4'h0, 8'd16, 8'd8, 1'b1, {1'b1, 32'h7FFFFFFF});
    drain();
    bus.out_ready = 1'b0;
    send(32'h00000111, 4'h0, 8'd16, 8'd16, 1'b0, '0);
    send(32'h00000222, 4'h0, 8'd16, 8'd16, 1'b0, '0);
    #2;
    reset   = 1'b0;
    sb.delete();
    exp_cnt = 0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_rst_sat_count", 64'(sat_count), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    send(32'h0000ABCD, 4'h0, 8'd16, 8'd16, 1'b1, {1'b0, 32'h0000ABCD});
    latency_check("post_rst", 32'h0000ABCD);
    drain();

    // Randomized traffic with random backpressure and clears
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom % 4 == 0) begin
            @(posedge clk);
            #1;
          end
          case ($urandom % 3)
            0:       rd = $urandom;
            1:       rd = 32'($urandom_range(0, 4095));
            default: rd = -32'($urandom_range(0, 4095));
          endcase
          rf = ($urandom % 3 == 0) ? 4'h3 : 4'($urandom % 16);
          send(rd, rf, 8'($urandom_range(0, 40)), 8'($urandom_range(0, 40)), 1'b0, '0);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom % 4) != 0;
          clear_sat     = ($urandom % 40) == 0;
        end
        bus.out_ready = 1'b1;
        clear_sat     = 1'b0;
      end
    join
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/calculus_requant_stage.md
Name: calculus_requant_stage

Overview:
- Downstream stage of the SIMD calculus unit.
- Takes each calculus result, re-scales it from source fixed-point format to destination fixed-point format (shift, optional rounding, saturation), and forwards it to the SIMD writeback path.
- 2-stage pipeline with valid/ready handshake, so writeback backpressure never drops a result.
- Counts saturation events for debug/status readout.

Parameters:
- BIT_WIDTH, 32, data width of input and output words (two's complement)
- FUNCTION_BITS, 4, width of the calculus function code carried with each beat
- SAT_CNT_BITS, 16, width of the saturation event counter

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  input beat valid
- in_ready  output  1  stage can accept input beat
- in_data  input  BIT_WIDTH  calculus result (signed)
- in_fn  input  FUNCTION_BITS  function code that produced in_data
- src_integer_bits  input  8  integer bits of in_data format
- dest_integer_bits  input  8  integer bits of output format
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts output beat
- out_data  output  BIT_WIDTH  requantized result (signed)
- out_sat  output  1  out_data was saturated
- clear_sat  input  1  synchronous clear of sat_count
- sat_count  output  SAT_CNT_BITS  saturation events since reset/clear

Behaviour:
- Reset, asynchronous, while reset=0:
  - All pipeline valids = 0; out_valid = 0, out_data = 0, out_sat = 0, sat_count = 0.
  - In-flight beats are discarded. First acceptance is the first clk edge after release.
- Handshake:
  - A transfer occurs on a clk edge where valid && ready.
  - s2_adv = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_adv (combinational).
  - Full throughput of 1 beat/cycle. Latency in_data -> out_data is 2 cycles with out_ready held high.
  - Once out_valid is high, out_data and out_sat hold stable until transfer. Beat order is preserved.
- Stage 1:
  - Registers data, fn and both integer-bit fields with the beat. Format fields are per-beat, not static.
  - Clamps each integer-bit value to [1, BIT_WIDTH].
  - Integer path: if fn == 4'b0011 (sign result), the source format is treated as pure integer (src = BIT_WIDTH).
  - Computes signed shift d = dest - src (range -(BIT_WIDTH-1)..BIT_WIDTH-1).
- Stage 2:
  - d = 0: pass-through.
  - d > 0: arithmetic right shift by d, truncation (floor).
  - d < 0: left shift by k = -d.
    - Overflow when bits [BIT_WIDTH-1 : BIT_WIDTH-1-k] of the operand are not all equal.
    - On overflow: positive -> 2^(BIT_WIDTH-1)-1, negative -> -2^(BIT_WIDTH-1), and out_sat = 1.
  - Registers the result into out_data/out_sat when s2_adv.
- sat_count:
  - Increments on each output transfer with out_sat = 1.
  - Sticks at all-ones (no wrap).
  - clear_sat sets it to 0 on the next edge; clear wins over a simultaneous increment.

Optional Feature:
- Macro: CALC_REQUANT_ROUND_EN.
- Defined, for d > 0:
  - Adds 2^(d-1) before the shift: round half toward +inf.
  - Sum computed in BIT_WIDTH+1 bits, so no wraparound; the result can never overflow.
- Undefined: truncation only, no adder instantiated.
- Latency and handshake identical in both builds.

Test Plan:
- Pass-through, src=16, dest=16, fn=0000:
  - in 0x00012345 -> out 0x00012345 two cycles later, out_sat=0.
- Right shift, src=8, dest=16:
  - in 0x00001280 -> out 0x00000012 (truncating build); 0x00000013 with CALC_REQUANT_ROUND_EN.
  - in 0xFFFFFFFF -> 0xFFFFFFFF (trunc); 0x00000000 (round).
- Left shift, src=16, dest=8:
  - in 0x00800000 -> 0x7FFFFFFF, out_sat=1, sat_count=1.
  - in 0xFF800000 -> 0x80000000, out_sat=0 (exact boundary, no saturation).
- Sign path, fn=0011:
  - in 0xFFFFFFFF with dest=16 -> 0xFFFF0000.
  - in 0x00000001 with dest=1 -> 0x7FFFFFFF, out_sat=1.
- Backpressure:
  - Offer 4 back-to-back beats with out_ready=0 for 5 cycles.
  - in_ready drops after 2 beats are held; out_data stays stable.
  - After out_ready rises, all 4 beats emerge in order, 1/cycle.
  - clear_sat pulsed in the same cycle as a saturating transfer -> sat_count=0.
- Reset mid-stream:
  - Drive reset=0 with 2 beats in flight.
  - out_valid=0 immediately, without waiting for a clk edge, and sat_count=0.
  - After release, the first new beat appears 2 cycles after acceptance with no stale data.
